// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request/response handshake plus data-memory port.
// Ports: slave = controller side, master = core/memory side.
//   req_valid/req_ready/req_write/req_wide/req_addr/req_wdata : request channel
//   resp_valid/resp_data : one-cycle completion pulse and result
//   mem_we/mem_w_addr/mem_w_data/mem_r_addr/mem_r_data : memory port
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic                    req_wide;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;

  logic                    resp_valid;
  logic [2*DATA_WIDTH-1:0] resp_data;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_w_addr;
  logic [2*DATA_WIDTH-1:0] mem_w_data;
  logic [ADDR_WIDTH-1:0]   mem_r_addr;
  logic [DATA_WIDTH-1:0]   mem_r_data;

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_wide,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_data,
    output mem_we,
    output mem_w_addr,
    output mem_w_data,
    output mem_r_addr,
    input  mem_r_data
  );

  modport master (
    output req_valid,
    output req_write,
    output req_wide,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  mem_we,
    input  mem_w_addr,
    input  mem_w_data,
    input  mem_r_addr,
    output mem_r_data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences byte/word reads and word writes onto data memory.
// Ports: clk, rst (sync, active-high), bus (mem_access_ctrl_if.slave).
//   Word reads are two byte reads assembled little-endian.
//   All mem_* outputs come from registers; only rst gates mem_we/req_ready.
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  mem_access_ctrl_if.slave bus
);

  localparam int WW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD0,
    RD1,
    RD2,
    DONE
  } state_t;

  typedef struct packed {
    logic                  wide;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WW-1:0]         wdata;
  } req_t;

  state_t                state;
  req_t                  req_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  ready_q;
  logic                  we_q;
  logic                  rv_q;
  logic [WW-1:0]         rdata_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH-1:0] addr_inc;

  // Wraps modulo 2^ADDR_WIDTH, matching the memory's own write wrap.
  assign addr_inc = req_q.addr + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      lo_q    <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      raddr_q <= '0;
    end else begin
      we_q <= 1'b0;
      rv_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_q.wide  <= bus.req_wide;
            req_q.addr  <= bus.req_addr;
            req_q.wdata <= bus.req_wdata;
            raddr_q     <= bus.req_addr;
            ready_q     <= 1'b0;
            if (bus.req_write) begin
              state <= WR;
              we_q  <= 1'b1;
            end else begin
              state <= RD0;
            end
          end
        end
        WR: begin
          state   <= DONE;
          rv_q    <= 1'b1;
          rdata_q <= req_q.wdata;
        end
        RD0: begin
          state <= RD1;
          // Second byte address goes out while the first byte returns.
          if (req_q.wide) begin
            raddr_q <= addr_inc;
          end
        end
        RD1: begin
          lo_q <= bus.mem_r_data;
          if (req_q.wide) begin
            state   <= RD2;
            raddr_q <= req_q.addr;
          end else begin
            state   <= DONE;
            rv_q    <= 1'b1;
            rdata_q <= {{DATA_WIDTH{1'b0}}, bus.mem_r_data};
          end
        end
        RD2: begin
          state   <= DONE;
          rv_q    <= 1'b1;
          rdata_q <= {bus.mem_r_data, lo_q};
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // rst gating keeps a write in WR from committing on the reset edge.
  assign bus.req_ready  = ready_q & ~rst;
  assign bus.mem_we     = we_q & ~rst;
  assign bus.resp_valid = rv_q;
  assign bus.resp_data  = rdata_q;
  assign bus.mem_w_addr = req_q.addr;
  assign bus.mem_w_data = req_q.wdata;
  assign bus.mem_r_addr = raddr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench with a behavioural byte memory.
// Memory: 256 x 8, registered read, little-endian 16-bit write.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;

  int nvec = 0;
  int nerr = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  int a0;
  int r0;

  logic [7:0] mem [256];
  logic [7:0] wa1;

  mem_access_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  mem_access_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign wa1 = bus.mem_w_addr + 8'd1;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_w_addr] <= bus.mem_w_data[7:0];
      mem[wa1]            <= bus.mem_w_data[15:8];
    end else begin
      bus.mem_r_data <= mem[bus.mem_r_addr];
    end
  end

  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
    if (bus.resp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    tick();
  endtask

  task automatic wait_resp(input string tag, input int lat_exp,
                           input logic [15:0] data_exp);
    int lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, lat_exp);
    chk({tag, "_rv"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, bus.resp_data}, {16'd0, data_exp});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[2]  = 8'h03;
    mem[15] = 8'h01;
    mem[16] = 8'h02;
    mem[21] = 8'h07;
    mem[23] = 8'h09;
    mem[50] = 8'h11;
    mem[51] = 8'h22;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_wide  = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 16'h0000;

    // Reset state
    tick();
    tick();
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rv", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rdata", {16'd0, bus.resp_data}, 32'd0);
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_waddr", {24'd0, bus.mem_w_addr}, 32'd0);
    chk("rst_wdata", {16'd0, bus.mem_w_data}, 32'd0);
    chk("rst_raddr", {24'd0, bus.mem_r_addr}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    // Word read at 15
    bus.req_write = 1'b0;
    bus.req_wide  = 1'b1;
    bus.req_addr  = 8'd15;
    bus.req_valid = 1'b1;
    accept("w15");
    bus.req_valid = 1'b0;
    chk("w15_c1_raddr", {24'd0, bus.mem_r_addr}, 32'd15);
    chk("w15_c1_we", {31'd0, bus.mem_we}, 32'd0);
    chk("w15_c1_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk("w15_c2_raddr", {24'd0, bus.mem_r_addr}, 32'd16);
    chk("w15_c2_we", {31'd0, bus.mem_we}, 32'd0);
    tick();
    chk("w15_c3_raddr", {24'd0, bus.mem_r_addr}, 32'd15);
    chk("w15_c3_rv", {31'd0, bus.resp_valid}, 32'd0);
    chk("w15_c3_we", {31'd0, bus.mem_we}, 32'd0);
    tick();
    chk("w15_c4_rv", {31'd0, bus.resp_valid}, 32'd1);
    chk("w15_c4_data", {16'd0, bus.resp_data}, 32'h0201);
    chk("w15_c4_we", {31'd0, bus.mem_we}, 32'd0);
    tick();
    chk("w15_c5_rv", {31'd0, bus.resp_valid}, 32'd0);
    chk("w15_c5_hold", {16'd0, bus.resp_data}, 32'h0201);
    chk("w15_c5_ready", {31'd0, bus.req_ready}, 32'd1);

    // Byte read at 2
    bus.req_wide  = 1'b0;
    bus.req_addr  = 8'd2;
    bus.req_valid = 1'b1;
    accept("b2");
    bus.req_valid = 1'b0;
    chk("b2_c1_raddr", {24'd0, bus.mem_r_addr}, 32'd2);
    tick();
    chk("b2_c2_raddr", {24'd0, bus.mem_r_addr}, 32'd2);
    tick();
    chk("b2_c3_rv", {31'd0, bus.resp_valid}, 32'd1);
    chk("b2_c3_data", {16'd0, bus.resp_data}, 32'h0003);
    chk("b2_c3_raddr", {24'd0, bus.mem_r_addr}, 32'd2);
    tick();
    chk("b2_c4_ready", {31'd0, bus.req_ready}, 32'd1);

    // Write BEEF at 40, read held pending, then word read at 40
    bus.req_write = 1'b1;
    bus.req_addr  = 8'd40;
    bus.req_wdata = 16'hBEEF;
    bus.req_valid = 1'b1;
    accept("wr40");
    chk("wr40_we", {31'd0, bus.mem_we}, 32'd1);
    chk("wr40_waddr", {24'd0, bus.mem_w_addr}, 32'd40);
    chk("wr40_wdata", {16'd0, bus.mem_w_data}, 32'hBEEF);
    chk("wr40_busy", {31'd0, bus.req_ready}, 32'd0);
    bus.req_write = 1'b0;
    bus.req_wide  = 1'b1;
    tick();
    chk("wr40_rv", {31'd0, bus.resp_valid}, 32'd1);
    chk("wr40_rdata", {16'd0, bus.resp_data}, 32'hBEEF);
    chk("wr40_busy2", {31'd0, bus.req_ready}, 32'd0);
    chk("wr40_we_off", {31'd0, bus.mem_we}, 32'd0);
    tick();
    chk("wr40_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mem40", {24'd0, mem[40]}, 32'hEF);
    chk("mem41", {24'd0, mem[41]}, 32'hBE);
    a0 = acc_cnt;
    tick();
    bus.req_valid = 1'b0;
    chk("rd40_acc", acc_cnt, a0 + 1);
    wait_resp("rd40", 4, 16'hBEEF);
    tick();

    // Wrap: write 1234 at 255, then word read at 255
    bus.req_write = 1'b1;
    bus.req_wide  = 1'b0;
    bus.req_addr  = 8'd255;
    bus.req_wdata = 16'h1234;
    bus.req_valid = 1'b1;
    accept("wr255");
    bus.req_valid = 1'b0;
    wait_resp("wr255", 2, 16'h1234);
    tick();
    chk("mem255", {24'd0, mem[255]}, 32'h34);
    chk("mem0", {24'd0, mem[0]}, 32'h12);
    bus.req_write = 1'b0;
    bus.req_wide  = 1'b1;
    bus.req_valid = 1'b1;
    accept("rd255");
    bus.req_valid = 1'b0;
    chk("rd255_c1_raddr", {24'd0, bus.mem_r_addr}, 32'd255);
    tick();
    chk("rd255_c2_raddr", {24'd0, bus.mem_r_addr}, 32'd0);
    tick();
    tick();
    chk("rd255_rv", {31'd0, bus.resp_valid}, 32'd1);
    chk("rd255_data", {16'd0, bus.resp_data}, 32'h1234);
    tick();

    // Reset during WR of AAAA at 50; valid coincident with rst
    r0 = rsp_cnt;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'd50;
    bus.req_wdata = 16'hAAAA;
    bus.req_valid = 1'b1;
    accept("wr50");
    rst = 1'b1;
    #1;
    chk("wr50_we_gated", {31'd0, bus.mem_we}, 32'd0);
    chk("wr50_ready", {31'd0, bus.req_ready}, 32'd0);
    a0 = acc_cnt;
    tick();
    chk("mem50", {24'd0, mem[50]}, 32'h11);
    chk("mem51", {24'd0, mem[51]}, 32'h22);
    chk("mr_rv", {31'd0, bus.resp_valid}, 32'd0);
    chk("mr_rdata", {16'd0, bus.resp_data}, 32'd0);
    chk("mr_we", {31'd0, bus.mem_we}, 32'd0);
    chk("mr_waddr", {24'd0, bus.mem_w_addr}, 32'd0);
    chk("mr_wdata", {16'd0, bus.mem_w_data}, 32'd0);
    chk("mr_raddr", {24'd0, bus.mem_r_addr}, 32'd0);
    chk("mr_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("mr_rel_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mr_no_acc", acc_cnt, a0);
    chk("mr_rel_waddr", {24'd0, bus.mem_w_addr}, 32'd0);
    tick();
    tick();
    tick();
    chk("mr_no_resp", rsp_cnt, r0);
    chk("mem50_after", {24'd0, mem[50]}, 32'h11);

    // Back-to-back byte reads at 21 and 23 with valid held
    r0 = rsp_cnt;
    a0 = acc_cnt;
    bus.req_write = 1'b0;
    bus.req_wide  = 1'b0;
    bus.req_addr  = 8'd21;
    bus.req_valid = 1'b1;
    accept("b21");
    bus.req_addr = 8'd23;
    wait_resp("b21", 3, 16'h0007);
    tick();
    chk("b23_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    wait_resp("b23", 3, 16'h0009);
    tick();
    tick();
    tick();
    chk("bb_acc", acc_cnt, a0 + 2);
    chk("bb_resp", rsp_cnt, r0 + 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side controller that drives the data memory's port on behalf of the core datapath. It takes single byte-read, 16-bit word-read and 16-bit word-write requests over a valid/ready handshake and sequences them onto the memory port. It accounts for the memory's one-cycle registered read and its read/write exclusivity. Word reads are assembled little-endian from two byte reads, matching the memory's little-endian 16-bit write.

## Interface
- DATA_WIDTH, 8, memory byte width; word width is 2*DATA_WIDTH
- ADDR_WIDTH, 8, memory byte-address width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = word write, 0 = read
- req_wide  in  1  for reads: 1 = 16-bit word, 0 = single byte (ignored on writes)
- req_addr  in  ADDR_WIDTH  byte address (word low byte)
- req_wdata  in  2*DATA_WIDTH  write word, [7:0] at addr, [15:8] at addr+1
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  2*DATA_WIDTH  read result (byte reads zero-extended); written word for writes
- mem_we  out  1  memory write enable
- mem_w_addr  out  ADDR_WIDTH  memory write address
- mem_w_data  out  2*DATA_WIDTH  memory write word
- mem_r_addr  out  ADDR_WIDTH  memory read address
- mem_r_data  in  DATA_WIDTH  memory registered read data, valid the cycle after mem_r_addr is sampled with mem_we=0

## Operation
- States: IDLE, WR, RD0, RD1, RD2, DONE.
- IDLE: req_ready=1. On req_valid&req_ready, latch addr, wdata, write and wide flags. Go to WR if write, else RD0.
- WR: mem_we=1, mem_w_addr=latched addr, mem_w_data=latched wdata. Go to DONE.
- RD0: mem_r_addr=addr. Go to RD1.
- RD1: capture mem_r_data into low byte. For a word read, drive mem_r_addr=addr+1 and go to RD2; otherwise go to DONE.
- RD2: capture mem_r_data into high byte. Go to DONE.
- DONE: resp_valid=1. resp_data = assembled word, or {8'h00, low byte} for byte reads, or the written word for writes. Go to IDLE.
- mem_we=0 in every state except WR, so reads are never blocked by the memory's write priority.
- Address arithmetic is modulo 2^ADDR_WIDTH: addr+1 of 255 is 0, consistent with the memory's write wrap.
- mem_w_addr and mem_w_data hold the latched request at all times.
- mem_r_addr is addr in IDLE/RD0/RD2/WR/DONE and addr+1 only in RD1 of a word read.
- mem_* outputs depend only on registered state. There is no combinational path from req_* to mem_*.
- req_ready=0 outside IDLE. Requests presented while busy are not accepted and must be held by the requester.
- resp_data holds its value until the next DONE.

## Timing
- Accept edge E0 (req_valid&req_ready sampled high).
- Write: WR in cycle 1, memory commits at E1. resp_valid in cycle 2. req_ready again in cycle 3.
- Byte read: RD0 cycle 1, RD1 cycle 2, resp_valid cycle 3. Next accept possible at end of cycle 4.
- Word read: RD0 cycle 1, RD1 cycle 2, RD2 cycle 3, resp_valid cycle 4.
- Throughput: at most one request every 3 (write), 4 (byte read) or 5 (word read) cycles.
- Reset values: state IDLE, req_ready=0 while rst is high and 1 the cycle after; resp_valid=0, resp_data=0, mem_we=0, all mem addresses 0, mem_w_data=0.
- Reset mid-operation: the in-flight request is dropped with no resp_valid. mem_we is gated by !rst, so no write commits on the reset edge even if the state is WR.
- A req_valid coincident with rst is not accepted.

## Test plan
- Init memory (mem[15]=1, mem[16]=2). Word read at 15 -> resp_valid exactly 4 cycles after accept, resp_data=16'h0201, mem_we low throughout.
- Byte read at addr 2 (mem[2]=3) -> resp_data=16'h0003 at cycle 3. mem_r_addr never equals 3.
- Word write 16'hBEEF at 40, then word read at 40 -> mem[40]=8'hEF, mem[41]=8'hBE, resp_data=16'hBEEF. req_ready low while busy, second request accepted in first IDLE cycle.
- Wrap: word write 16'h1234 at 255, then word read at 255 -> mem[255]=8'h34, mem[0]=8'h12; read sequence drives mem_r_addr 255 then 0, resp_data=16'h1234.
- Reset in WR cycle of a write of 16'hAAAA to 50 -> mem[50:51] unchanged, no resp_valid. Next cycle all outputs at reset values; req_ready=1 after rst drops.
- req_valid held high across back-to-back reads at 21 and 23 (mem 7 and 9, byte mode) -> two resp_valid pulses, resp_data 16'h0007 then 16'h0009, each request accepted exactly once.
